// File: rtl/backlight_temporal_filter.sv
// ---------------------------------------------------------------------------
// backlight_temporal_filter
//
// Per-zone temporal filter between the local-dimming algorithm and the
// MiniLED driver. Targets are captured into a target RAM; on each frame
// pulse every zone is swept through an asymmetric IIR (fast rise, slow
// fall), the result is stored as the new filter state, scaled by the
// ambient brightness gain and written into the inactive half of a
// ping-pong output buffer. The driver always reads the stable bank.
//
// Ports:
//   I_clk, I_rst_n   clock, asynchronous active-low reset
//   I_zone_we        target write strobe (ignored while O_busy)
//   I_zone_addr      target zone index, >= ZONES silently ignored
//   I_zone_data      target luminance
//   I_frame_done     pulse: start a sweep (ignored unless idle)
//   I_bright         ambient brightness code (floored at MIN_GAIN)
//   I_bypass         1 = output follows target with no filtering
//   I_rd_addr        driver read address
//   O_rd_data        registered read data, latency 1, from active bank
//   O_busy           sweep in progress (LOAD, RUN, FLUSH)
//   O_frame_done     one-cycle pulse on bank swap
//   O_overrun        one-cycle pulse per dropped write / frame pulse
// ---------------------------------------------------------------------------
module backlight_temporal_filter #(
  parameter int ZONES      = 360,
  parameter int RISE_SHIFT = 1,
  parameter int FALL_SHIFT = 3,
  parameter int MIN_GAIN   = 32
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       I_zone_we,
  input  logic [8:0] I_zone_addr,
  input  logic [7:0] I_zone_data,
  input  logic       I_frame_done,
  input  logic [7:0] I_bright,
  input  logic       I_bypass,
  input  logic [8:0] I_rd_addr,
  output logic [7:0] O_rd_data,
  output logic       O_busy,
  output logic       O_frame_done,
  output logic       O_overrun
);

  localparam logic [8:0] NUM_ZONES = 9'(ZONES);
  localparam logic [8:0] LAST_IDX  = 9'(ZONES - 1);
  localparam logic [7:0] GAIN_MIN  = 8'(MIN_GAIN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_FLUSH,
    S_SWAP
  } state_t;

  state_t     state_q, state_d;
  logic [8:0] idx_q;
  logic       flush_q;
  logic [7:0] gain_q;
  logic       bypass_q;
  logic       bank_q;
  logic       init_done_q;
  logic       out_valid_q;
  logic       s1_valid_q;
  logic [8:0] s1_idx_q;
  logic [7:0] tgt_rd_q;
  logic [7:0] prev_rd_q;

  logic       busy;
  logic       run_issue;
  logic       tgt_we;
  logic       wr_addr_ok;
  logic [7:0] step;
  logic [7:0] n_val;
  logic [8:0] gain_p1;
  logic [15:0] prod;
  logic [7:0] o_val;

  logic [7:0] tgt_mem  [ZONES];
  logic [7:0] st_mem   [ZONES];
  logic [7:0] out_mem0 [ZONES];
  logic [7:0] out_mem1 [ZONES];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (!I_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned
    // (otherwise a latch is inferred).
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (I_frame_done) state_d = S_LOAD;
      S_LOAD:  state_d = S_RUN;
      S_RUN:   if (idx_q == LAST_IDX) state_d = S_FLUSH;
      S_FLUSH: if (flush_q) state_d = S_SWAP;
      S_SWAP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy      = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_FLUSH);
    run_issue = (state_q == S_RUN);
  end

  assign O_busy     = busy;
  assign wr_addr_ok = (I_zone_addr < NUM_ZONES);
  assign tgt_we     = I_zone_we && wr_addr_ok && !busy;

  // ---------------- control / pipeline registers ----------------
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      idx_q        <= '0;
      flush_q      <= 1'b0;
      gain_q       <= '0;
      bypass_q     <= 1'b0;
      bank_q       <= 1'b0;
      init_done_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_idx_q     <= '0;
      O_frame_done <= 1'b0;
      O_overrun    <= 1'b0;
    end else begin
      O_frame_done <= (state_q == S_SWAP);
      // Out-of-range writes are dropped silently even while busy.
      O_overrun    <= (I_zone_we && wr_addr_ok && busy) ||
                      (I_frame_done && (state_q != S_IDLE));
      s1_valid_q   <= run_issue;
      s1_idx_q     <= idx_q;

      if (state_q == S_LOAD) begin
        gain_q   <= (I_bright < GAIN_MIN) ? GAIN_MIN : I_bright;
        bypass_q <= I_bypass;
        idx_q    <= '0;
      end
      if (run_issue) idx_q <= idx_q + 9'd1;

      if (state_q == S_RUN)   flush_q <= 1'b0;
      if (state_q == S_FLUSH) flush_q <= 1'b1;

      if (state_q == S_SWAP) begin
        bank_q      <= ~bank_q;
        init_done_q <= 1'b1;
        out_valid_q <= 1'b1;
      end
    end
  end

  // ---------------- filter arithmetic ----------------
  always_comb begin
    step  = '0;
    n_val = tgt_rd_q;
    if (init_done_q && !bypass_q) begin
      if (tgt_rd_q > prev_rd_q) begin
        step  = (tgt_rd_q - prev_rd_q) >> RISE_SHIFT;
        if (step == 8'd0) step = 8'd1;
        n_val = prev_rd_q + step;
      end else if (tgt_rd_q < prev_rd_q) begin
        step  = (prev_rd_q - tgt_rd_q) >> FALL_SHIFT;
        if (step == 8'd0) step = 8'd1;
        n_val = prev_rd_q - step;
      end else begin
        n_val = prev_rd_q;
      end
    end
  end

  // g+1 so that g=255 is an exact unity gain after the >>8.
  assign gain_p1 = {1'b0, gain_q} + 9'd1;
  assign prod    = {8'd0, n_val} * {7'd0, gain_p1};
  assign o_val   = 8'(prod >> 8);

  // ---------------- RAMs ----------------
  // NOTE: the RAM arrays carry no reset; their contents are only meaningful
  // once written, and leaving them reset-free lets them map to block RAM.
  always_ff @(posedge I_clk) begin
    if (tgt_we) tgt_mem[I_zone_addr] <= I_zone_data;
    if (run_issue) begin
      tgt_rd_q  <= tgt_mem[idx_q];
      prev_rd_q <= st_mem[idx_q];
    end
    if (s1_valid_q) begin
      st_mem[s1_idx_q] <= n_val;
      // The inactive bank is the one the driver is not reading.
      if (bank_q) out_mem0[s1_idx_q] <= o_val;
      else        out_mem1[s1_idx_q] <= o_val;
    end
  end

  // ---------------- driver read port ----------------
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_rd_data <= '0;
    end else if (out_valid_q && (I_rd_addr < NUM_ZONES)) begin
      O_rd_data <= bank_q ? out_mem1[I_rd_addr] : out_mem0[I_rd_addr];
    end else begin
      O_rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_backlight_temporal_filter.sv
// ---------------------------------------------------------------------------
// Self-checking bench for backlight_temporal_filter: table-driven frames on
// two zones with hand-computed expectations, hand sequences for fall-to-zero,
// rise, overrun and mid-sweep reset, and randomized frames checked against a
// zone-by-zone arithmetic model of the filter.
// ---------------------------------------------------------------------------
module tb_backlight_temporal_filter;

  localparam int ZONES = 360;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       zone_we = 1'b0;
  logic [8:0] zone_addr = '0;
  logic [7:0] zone_data = '0;
  logic       frame_done = 1'b0;
  logic [7:0] bright = 8'd255;
  logic       bypass = 1'b0;
  logic [8:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       busy;
  logic       frame_done_o;
  logic       overrun;

  backlight_temporal_filter dut (
    .I_clk        (clk),
    .I_rst_n      (rst_n),
    .I_zone_we    (zone_we),
    .I_zone_addr  (zone_addr),
    .I_zone_data  (zone_data),
    .I_frame_done (frame_done),
    .I_bright     (bright),
    .I_bypass     (bypass),
    .I_rd_addr    (rd_addr),
    .O_rd_data    (rd_data),
    .O_busy       (busy),
    .O_frame_done (frame_done_o),
    .O_overrun    (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int start_cyc = 0;

  // Reference model state
  int m_tgt  [ZONES];
  int m_prev [ZONES];
  int m_out  [ZONES];
  bit m_init  = 1'b0;
  bit m_valid = 1'b0;

  typedef struct {
    logic [7:0] t5;
    logic [7:0] t6;
    logic [7:0] br;
    logic       byp;
    logic [7:0] e5;
    logic [7:0] e6;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One frame of the filter, evaluated zone by zone from the rules.
  task automatic model_frame();
    int g, t, p, n, s;
    g = (bright < 8'd32) ? 32 : int'(bright);
    for (int z = 0; z < ZONES; z++) begin
      t = m_tgt[z];
      p = m_prev[z];
      if (!m_init || bypass) n = t;
      else if (t > p) begin
        s = (t - p) / 2;
        if (s == 0) s = 1;
        n = p + s;
      end else if (t < p) begin
        s = (p - t) / 8;
        if (s == 0) s = 1;
        n = p - s;
      end else n = p;
      m_prev[z] = n;
      m_out[z]  = (n * (g + 1)) / 256;
    end
    m_init  = 1'b1;
    m_valid = 1'b1;
  endtask

  task automatic write_zone(input int a, input int d);
    @(negedge clk);
    zone_we   = 1'b1;
    zone_addr = 9'(a);
    zone_data = 8'(d);
    @(posedge clk);
    #1;
    zone_we = 1'b0;
    if (a < ZONES) m_tgt[a] = d;
  endtask

  task automatic start_frame(input bit with_wr, input int a, input int d);
    @(negedge clk);
    frame_done = 1'b1;
    if (with_wr) begin
      zone_we   = 1'b1;
      zone_addr = 9'(a);
      zone_data = 8'(d);
    end
    @(posedge clk);
    #1;
    start_cyc  = cyc;
    frame_done = 1'b0;
    zone_we    = 1'b0;
    if (with_wr && a < ZONES) m_tgt[a] = d;
    model_frame();
  endtask

  task automatic wait_frame();
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (frame_done_o) break;
    end
    check("frame_latency", cyc - start_cyc, ZONES + 4);
  endtask

  task automatic read_zone(input int a, output logic [7:0] d);
    @(negedge clk);
    rd_addr = 9'(a);
    @(posedge clk);
    #1;
    d = rd_data;
  endtask

  task automatic check_all(input string name);
    logic [7:0] d;
    for (int z = 0; z < ZONES; z++) begin
      read_zone(z, d);
      check(name, d, (m_valid ? m_out[z] : 0));
    end
  endtask

  initial begin
    logic [7:0] d;
    int iter;

    vecs[0] = '{t5: 200, t6: 0,   br: 255, byp: 0, e5: 200, e6: 0};
    vecs[1] = '{t5: 0,   t6: 1,   br: 255, byp: 0, e5: 175, e6: 1};
    vecs[2] = '{t5: 0,   t6: 255, br: 255, byp: 0, e5: 154, e6: 128};
    vecs[3] = '{t5: 0,   t6: 255, br: 255, byp: 0, e5: 135, e6: 191};
    vecs[4] = '{t5: 200, t6: 255, br: 10,  byp: 0, e5: 21,  e6: 28};
    vecs[5] = '{t5: 80,  t6: 0,   br: 255, byp: 1, e5: 80,  e6: 0};
    vecs[6] = '{t5: 80,  t6: 0,   br: 255, byp: 0, e5: 80,  e6: 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_frame_done", frame_done_o, 0);
    check("reset_overrun", overrun, 0);
    check("reset_rd_data", rd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int z = 0; z < ZONES; z++) write_zone(z, 200);
    read_zone(0, d);
    check("read_before_swap", d, 0);

    // Table-driven frames on zones 5 and 6
    for (int i = 0; i < 7; i++) begin
      bright = vecs[i].br;
      bypass = vecs[i].byp;
      write_zone(5, vecs[i].t5);
      write_zone(6, vecs[i].t6);
      start_frame(1'b0, 0, 0);
      wait_frame();
      @(posedge clk);
      #1;
      check("frame_done_width", frame_done_o, 0);
      read_zone(5, d);
      check("vec_zone5", d, vecs[i].e5);
      read_zone(6, d);
      check("vec_zone6", d, vecs[i].e6);
      if (i == 0 || i == 4) check_all("vec_all_zones");
    end
    read_zone(17, d);
    check("gain_floor_n200", d, 200);
    bypass = 1'b0;

    // Fall to exactly zero with no underflow
    write_zone(5, 0);
    iter = 0;
    while (m_prev[5] != 0 && iter < 80) begin
      start_frame(1'b0, 0, 0);
      wait_frame();
      read_zone(5, d);
      check("fall_zone5", d, m_out[5]);
      iter++;
    end
    start_frame(1'b0, 0, 0);
    wait_frame();
    read_zone(5, d);
    check("fall_floor_zero", d, 0);
    check("fall_iter_bound", (iter < 80), 1);

    // Rise from zero
    write_zone(5, 255);
    for (int i = 0; i < 3; i++) begin
      start_frame(1'b0, 0, 0);
      wait_frame();
      read_zone(5, d);
      check("rise_zone5", d, (i == 0) ? 127 : (i == 1) ? 191 : 223);
    end

    // Out-of-range reads
    read_zone(360, d);
    check("read_addr_360", d, 0);
    read_zone(511, d);
    check("read_addr_511", d, 0);

    // Overrun: write and frame pulse while busy
    start_frame(1'b0, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    check("busy_during_sweep", busy, 1);
    @(negedge clk);
    zone_we   = 1'b1;
    zone_addr = 9'd7;
    zone_data = 8'd13;
    @(posedge clk);
    #1;
    zone_we = 1'b0;
    check("overrun_write", overrun, 1);
    @(posedge clk);
    #1;
    check("overrun_write_width", overrun, 0);
    @(negedge clk);
    frame_done = 1'b1;
    @(posedge clk);
    #1;
    frame_done = 1'b0;
    check("overrun_frame", overrun, 1);
    @(posedge clk);
    #1;
    check("overrun_frame_width", overrun, 0);
    wait_frame();
    check_all("after_overrun");
    start_frame(1'b0, 0, 0);
    wait_frame();
    check_all("dropped_write_absent");

    // Randomized frames, first one with a write alongside the frame pulse
    for (int f = 0; f < 3; f++) begin
      for (int w = 0; w < 40; w++)
        write_zone($urandom_range(0, 511), $urandom_range(0, 255));
      bright = 8'($urandom_range(0, 255));
      bypass = ($urandom_range(0, 7) == 0);
      start_frame((f == 0), 20, 77);
      wait_frame();
      check_all("random_frame");
    end
    bypass = 1'b0;

    // Reset at RUN index 100, then an unfiltered frame
    start_frame(1'b0, 0, 0);
    repeat (101) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_rd_data", rd_data, 0);
    check("midreset_frame_done", frame_done_o, 0);
    m_init  = 1'b0;
    m_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    read_zone(3, d);
    check("midreset_read_invalid", d, 0);
    bright = 8'd100;
    start_frame(1'b0, 0, 0);
    wait_frame();
    check_all("post_reset_unfiltered");
    read_zone(5, d);
    check("post_reset_zone5", d, (m_tgt[5] * 101) / 256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
